// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline-control types and latch-control constants
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} ctrl_state_t;
  typedef struct packed {
    logic en;
    logic flush;
    logic freeze;
  } latch_ctrl_t;
  localparam latch_ctrl_t ADV  = 3'b100;
  localparam latch_ctrl_t HOLD = 3'b101;
  localparam latch_ctrl_t BUB  = 3'b110;
  localparam latch_ctrl_t OFF  = 3'b000;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard compare between id_ex and if_id
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             lu
);
  assign lu = ex_is_load && ex_rd != '0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-cycle stall/flush/halt sequencer for the pipeline latches and PC
module pipeline_ctrl import cpu_types_pkg::*; #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dreq,
  input  logic             dhit,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             br_mispredict,
  input  logic             mem_halt,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             ifid_freeze,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             idex_freeze,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             exmem_freeze,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             memwb_freeze,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  ctrl_state_t state, nxt;
  latch_ctrl_t c_if, c_id, c_ex, c_wb;
  logic lu, stall_inc, flush_inc;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_is_load(ex_is_load),
    .ex_rd(ex_rd),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .lu(lu)
  );

  assign {ifid_en, ifid_flush, ifid_freeze}    = c_if;
  assign {idex_en, idex_flush, idex_freeze}    = c_id;
  assign {exmem_en, exmem_flush, exmem_freeze} = c_ex;
  assign {memwb_en, memwb_flush, memwb_freeze} = c_wb;
  assign halt = state == HALTED && !RST;

  // Resolve this cycle's hazards by priority into latch controls, PC enable and next state
  always_comb begin
    c_if = ADV;
    c_id = ADV;
    c_ex = ADV;
    c_wb = ADV;
    pc_en = 1'b1;
    nxt = state;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (RST || state == HALTED) begin
      {c_if, c_id, c_ex, c_wb} = {OFF, OFF, OFF, OFF};
      pc_en = 1'b0;
      nxt = RST ? RUN : HALTED;
    end else if (state == DRAIN) begin
      {c_if, c_id, c_ex} = {BUB, BUB, BUB};
      pc_en = 1'b0;
      nxt = HALTED;
    end else if (state == RUN && mem_halt) begin
      {c_if, c_id, c_ex} = {BUB, BUB, BUB};
      pc_en = 1'b0;
      nxt = DRAIN;
    end else if (dreq && !dhit) begin
      {c_if, c_id, c_ex, c_wb} = {HOLD, HOLD, HOLD, HOLD};
      pc_en = 1'b0;
      nxt = DWAIT;
      stall_inc = 1'b1;
    end else begin
      nxt = RUN;
      if (br_mispredict) begin
        {c_if, c_id, c_ex} = {BUB, BUB, BUB};
        flush_inc = 1'b1;
      end else if (lu) begin
        {c_if, c_id} = {HOLD, BUB};
        pc_en = 1'b0;
        stall_inc = 1'b1;
      end else if (!ihit) begin
        c_if = BUB;
        pc_en = 1'b0;
        stall_inc = 1'b1;
      end
    end
  end

  // State register and performance counters; counters freeze once halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      cyc_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt;
      if (state != HALTED) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench with a behavioural model of the pipeline sequencer
module tb_pipeline_ctrl;
  localparam logic [2:0] A = 3'b100, H = 3'b101, B = 3'b110, O = 3'b000;
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

  logic CLK, RST, ihit, dreq, dhit, ex_is_load, id_use_rs1, id_use_rs2, br_mispredict, mem_halt;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic ifid_en, ifid_flush, ifid_freeze, idex_en, idex_flush, idex_freeze;
  logic exmem_en, exmem_flush, exmem_freeze, memwb_en, memwb_flush, memwb_freeze;
  logic pc_en, halt;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dreq(dreq), .dhit(dhit),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .br_mispredict(br_mispredict), .mem_halt(mem_halt),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .ifid_freeze(ifid_freeze),
    .idex_en(idex_en), .idex_flush(idex_flush), .idex_freeze(idex_freeze),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .exmem_freeze(exmem_freeze),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .memwb_freeze(memwb_freeze),
    .pc_en(pc_en), .halt(halt),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [11:0] lat;
    logic        pc;
    logic        hl;
    logic [31:0] cyc, stl, fl;
    bit          cnt_ok;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int mode = M_RUN;
  bit known = 0;
  logic [31:0] m_cyc = 0, m_stl = 0, m_fl = 0;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] msk(input logic [2:0] x);
    return x == H ? 3'b101 : x == B ? 3'b110 : 3'b111;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h required %h", n, $time, act, req);
    end
  endtask

  // Monitor: outputs are present every cycle; compare mid-cycle against the oldest expectation
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] act, m;
      e = q.pop_front();
      act = {ifid_en, ifid_flush, ifid_freeze, idex_en, idex_flush, idex_freeze,
             exmem_en, exmem_flush, exmem_freeze, memwb_en, memwb_flush, memwb_freeze};
      m = {msk(e.lat[11:9]), msk(e.lat[8:6]), msk(e.lat[5:3]), msk(e.lat[2:0])};
      chk("latch_ctrl", {20'd0, act & m}, {20'd0, e.lat & m});
      chk("pc_en", {31'd0, pc_en}, {31'd0, e.pc});
      chk("halt", {31'd0, halt}, {31'd0, e.hl});
      if (e.cnt_ok) begin
        chk("cyc_cnt", cyc_cnt, e.cyc);
        chk("stall_cnt", stall_cnt, e.stl);
        chk("flush_cnt", flush_cnt, e.fl);
      end
    end
  end

  // Model the cycle from the currently driven inputs, queue the expectation, then clock
  task automatic tick();
    exp_t e;
    bit lu;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e.cyc = m_cyc; e.stl = m_stl; e.fl = m_fl; e.cnt_ok = known;
    e.hl = 0; e.pc = 0;
    if (RST) begin
      e.lat = {O, O, O, O};
      mode = M_RUN; m_cyc = 0; m_stl = 0; m_fl = 0; known = 1;
    end else if (mode == M_HALT) begin
      e.lat = {O, O, O, O}; e.hl = 1;
    end else begin
      m_cyc++;
      if (mode == M_DRAIN) begin
        e.lat = {B, B, B, A}; mode = M_HALT;
      end else if (mode == M_RUN && mem_halt) begin
        e.lat = {B, B, B, A}; mode = M_DRAIN;
      end else if (dreq && !dhit) begin
        e.lat = {H, H, H, H}; mode = M_WAIT; m_stl++;
      end else begin
        mode = M_RUN;
        if (br_mispredict) begin e.lat = {B, B, B, A}; e.pc = 1; m_fl++; end
        else if (lu) begin e.lat = {H, B, A, A}; m_stl++; end
        else if (!ihit) begin e.lat = {B, A, A, A}; m_stl++; end
        else begin e.lat = {A, A, A, A}; e.pc = 1; end
      end
    end
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dreq = 0; dhit = 0; ex_is_load = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    br_mispredict = 0; mem_halt = 0;
  endtask

  initial begin
    idle();
    @(posedge CLK);
    #1;
    RST = 1; tick(); tick();
    RST = 0;
    repeat (11) tick();
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; tick();
    ex_rd = 0; tick();
    idle();
    dreq = 1; repeat (3) tick();
    dhit = 1; tick();
    idle(); tick();
    br_mispredict = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; ihit = 0; tick();
    idle(); tick();
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; ihit = 0; tick();
    idle();
    dreq = 1; br_mispredict = 1; tick(); tick();
    dhit = 1; tick();
    idle();
    mem_halt = 1; tick();
    idle(); repeat (7) tick();
    dreq = 1; repeat (2) tick();
    RST = 1; tick(); tick();
    idle(); repeat (3) tick();
    for (int i = 0; i < 3000; i++) begin
      RST = (mode == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0;
      ihit = $urandom_range(0, 5) != 0;
      dreq = $urandom_range(0, 2) == 0;
      dhit = $urandom_range(0, 1) == 0;
      ex_is_load = $urandom_range(0, 1) == 1;
      ex_rd = 5'($urandom_range(0, 7));
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_use_rs1 = $urandom_range(0, 1) == 1;
      id_use_rs2 = $urandom_range(0, 1) == 1;
      br_mispredict = $urandom_range(0, 7) == 0;
      mem_halt = $urandom_range(0, 59) == 0;
      tick();
    end
    idle();
    @(negedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the four pipeline latches (if_id, id_ex, ex_mem, mem_wb) and the PC register. Each cycle it resolves i-cache misses, d-cache waits, load-use hazards, branch mispredicts and halt, and drives each latch's en/flush/freeze and the PC enable. It tracks d-cache waits and halt drain in a small FSM. It also keeps cycle, stall and flush counters for performance checks.

Parameters:
CNT_W, 32, width of each performance counter
REG_W, 5, register-index width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ihit  in  1  fetch returned a valid instruction this cycle
dreq  in  1  ex_mem latch holds a load/store (dREN|dWEN)
dhit  in  1  d-cache completes the MEM access this cycle
ex_is_load  in  1  id_ex latch holds a load
ex_rd  in  REG_W  destination register of the id_ex instruction
id_rs1, id_rs2  in  REG_W  source registers of the if_id instruction
id_use_rs1, id_use_rs2  in  1  the if_id instruction reads rs1/rs2
br_mispredict  in  1  branch in MEM resolved opposite to the prediction
mem_halt  in  1  ex_mem latch holds HALT
ifid_en, ifid_flush, ifid_freeze  out  1 each  if_id latch controls
idex_en, idex_flush, idex_freeze  out  1 each  id_ex latch controls
exmem_en, exmem_flush, exmem_freeze  out  1 each  ex_mem latch controls
memwb_en, memwb_flush, memwb_freeze  out  1 each  mem_wb latch controls
pc_en  out  1  PC register may update
halt  out  1  sticky processor-halted flag
cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Latch control encoding:
  - ADV = en1/flush0/freeze0
  - HOLD = en1/freeze1
  - BUB = en1/flush1
  - OFF = en0/flush0/freeze0
- Reset: sampled on rising CLK. While RST=1:
  - all latches OFF, pc_en=0, halt=0
  - next state RUN; all counters cleared to 0
  - a mid-stall or mid-drain RST abandons the stall or drain.
- States: RUN, DWAIT, DRAIN, HALTED.
- Load-use hazard: lu = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN / DWAIT shared output priority, highest first:
  1. mem_halt (RUN only): ifid/idex/exmem BUB, memwb ADV, pc_en=0; next state DRAIN.
  2. dreq & !dhit: all four latches HOLD, pc_en=0; next state DWAIT. stall_cnt increments.
  3. br_mispredict: ifid/idex/exmem BUB, memwb ADV, pc_en=1 (PC loads the correct target); next state RUN. flush_cnt increments.
  4. lu: ifid HOLD, idex BUB, exmem/memwb ADV, pc_en=0. stall_cnt increments.
  5. !ihit: ifid BUB, idex/exmem/memwb ADV, pc_en=0. stall_cnt increments.
  6. Otherwise all ADV, pc_en=1.
- DWAIT exit: the first cycle dhit=1 is evaluated with rules 3–6 and the state returns to RUN. Zero-wait hits never enter DWAIT.
- mem_halt in DWAIT is ignored, since HALT never asserts dreq.
- Combined events (resolved by the priority order):
  - br_mispredict with lu or !ihit: mispredict wins and lu is discarded, because its consumer is flushed.
  - lu with !ihit: lu wins and ifid is held, not bubbled.
  - dreq&!dhit with br_mispredict: the hold wins. Mispredict stays asserted because ex_mem is frozen, and it is acted on in the dhit cycle.
- DRAIN (exactly 1 cycle): memwb ADV (HALT reaches WB), other latches BUB, pc_en=0; next state HALTED.
- HALTED: all latches OFF, pc_en=0, halt=1. Leaves only on RST.
- cyc_cnt increments every cycle outside HALTED and RST.
- Counters wrap modulo 2^CNT_W.
- All outputs except the counters and halt are combinational from state plus inputs. Latency from input to control is zero cycles.

Decomposition:
- Shared package (cpu_types_pkg): ctrl_state_t enum {RUN, DWAIT, DRAIN, HALTED}; latch_ctrl_t struct {en, flush, freeze}; constants ADV/HOLD/BUB/OFF.
- Sub-module hazard_detect: purely combinational lu compare, reused by a later forwarding unit.

Test Plan:
1. RST=1 for 2 cycles, then ihit=1 and no hazards → all latches ADV, pc_en=1; after 10 cycles cyc_cnt=10, stall_cnt=0.
2. ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1, ihit=1 → ifid HOLD, idex BUB, pc_en=0, stall_cnt+1. Repeat with ex_rd=0 → all ADV.
3. dreq=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles all HOLD in DWAIT with stall_cnt=3, then all ADV and state RUN.
4. br_mispredict=1 together with lu=1 and ihit=0 → ifid/idex/exmem BUB, memwb ADV, pc_en=1, flush_cnt=1, stall_cnt unchanged.
5. mem_halt=1 → DRAIN for 1 cycle with memwb ADV, then HALTED with all en=0 and halt=1. Counters stay frozen for 5 more cycles.
6. RST=1 asserted during DWAIT → next cycle state RUN, counters 0, halt=0. With RST held, all en=0.
